// File: rtl/risc_pkg.sv
// Shared types and constants for the multi-cycle RISC instruction sequencer.
package risc_pkg;

    // Sequencer states; the encoding is exported directly on the stage output.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Default interrupt vector address (truncated to the PC width by users).
    localparam logic [31:0] DEFAULT_INT_VEC = 32'h40;

endpackage : risc_pkg

// File: rtl/risc_sequencer_if.sv
// Bundle of decoder/branch inputs and datapath strobes around the sequencer.
// master: the sequencer itself; slave: decoder, memory and datapath side.
interface risc_sequencer_if #(
    parameter int AW = 32
);
    logic          INT;
    logic          stall;
    logic          is_mem;
    logic          is_branch;
    logic [AW-1:0] br_target;
    logic          is_reti;
    logic          is_halt;
    logic [AW-1:0] PC;
    logic [2:0]    stage;
    logic          ld_ir;
    logic          rdMem;
    logic          wrEn;
    logic          updPC;
    logic          int_ack;
    logic          in_isr;
    logic          halted;
    logic [AW-1:0] EPC;

    modport master (
        input  INT, stall, is_mem, is_branch, br_target, is_reti, is_halt,
        output PC, stage, ld_ir, rdMem, wrEn, updPC, int_ack, in_isr, halted, EPC
    );

    modport slave (
        output INT, stall, is_mem, is_branch, br_target, is_reti, is_halt,
        input  PC, stage, ld_ir, rdMem, wrEn, updPC, int_ack, in_isr, halted, EPC
    );
endinterface : risc_sequencer_if

// File: rtl/risc_sequencer_inc.sv
// N-bit incrementer (y = a + 1, wrapping at 2^N) built as a ripple of
// half adders so it maps onto plain LUT/carry logic for any width.
module incN #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);

    logic [N-1:0] carry;

    assign carry[0] = 1'b1;

    // One half-adder per bit; the carry out of the top bit is discarded.
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign y[gi] = a[gi] ^ carry[gi];
        if (gi < N - 1) begin : g_carry
            assign carry[gi+1] = a[gi] & carry[gi];
        end
    end

endmodule : incN

// File: rtl/risc_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, walks FETCH/DECODE/EXEC/
// MEM/WB, handles memory stalls, vectored interrupts with a saved return PC,
// return-from-interrupt with tail-chaining, and HALT with interrupt wake-up.
module risc_sequencer
    import risc_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [31:0]   INT_VEC  = DEFAULT_INT_VEC
) (
    input  logic             clk,
    input  logic             rst,
    risc_sequencer_if.master bus
);

    localparam logic [AW-1:0] VEC_ADDR = AW'(INT_VEC);

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [AW-1:0] epc_reg, epc_next;
    logic          pending_reg, pending_next;
    logic          in_isr_reg, in_isr_next;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] seq_pc;
    logic          int_req;
    logic          fetch_strobe;
    logic          mem_strobe;
    logic          wb_strobe;
    logic          upd_strobe;
    logic          ack_strobe;

    incN #(
        .N (AW)
    ) u_inc (
        .a (pc_reg),
        .y (pc_inc)
    );

    // A request sampled on an earlier edge, or present right now, counts;
    // this gives the one-cycle minimum latency when INT rises during WB.
    assign int_req = pending_reg | bus.INT;

    // Program-order successor of the instruction in WB.
    always_comb begin
        if (bus.is_reti) begin
            seq_pc = epc_reg;
        end else if (bus.is_branch) begin
            seq_pc = bus.br_target;
        end else begin
            seq_pc = pc_inc;
        end
    end

    // Next-state, next-PC/EPC and strobe decode for the stage machine.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        epc_next     = epc_reg;
        in_isr_next  = in_isr_reg;
        fetch_strobe = 1'b0;
        mem_strobe   = 1'b0;
        wb_strobe    = 1'b0;
        upd_strobe   = 1'b0;
        ack_strobe   = 1'b0;

        case (state_reg)
            FETCH: begin
                fetch_strobe = 1'b1;
                state_next   = DECODE;
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                state_next = bus.is_mem ? MEM : WB;
            end
            MEM: begin
                mem_strobe = 1'b1;
                if (!bus.stall) begin
                    state_next = WB;
                end
            end
            WB: begin
                wb_strobe  = 1'b1;
                upd_strobe = 1'b1;
                state_next = FETCH;
                if (int_req && (!in_isr_reg || bus.is_reti)) begin
                    // Take the interrupt; a reti here tail-chains and keeps
                    // the original return address.
                    ack_strobe  = 1'b1;
                    pc_next     = VEC_ADDR;
                    in_isr_next = 1'b1;
                    if (!bus.is_reti) begin
                        epc_next = seq_pc;
                    end
                end else if (bus.is_reti) begin
                    pc_next     = epc_reg;
                    in_isr_next = 1'b0;
                end else if (bus.is_halt) begin
                    pc_next    = pc_inc;
                    state_next = HALT;
                end else begin
                    pc_next = seq_pc;
                end
            end
            HALT: begin
                // Only an unmasked interrupt wakes the core; the halted
                // address becomes the return address.
                if (int_req && !in_isr_reg) begin
                    upd_strobe  = 1'b1;
                    ack_strobe  = 1'b1;
                    epc_next    = pc_reg;
                    pc_next     = VEC_ADDR;
                    in_isr_next = 1'b1;
                    state_next  = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // The request stays latched until it is acknowledged.
        pending_next = ack_strobe ? 1'b0 : int_req;
    end

    // Sequencer state, PC, EPC and interrupt bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            epc_reg     <= '0;
            pending_reg <= 1'b0;
            in_isr_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            epc_reg     <= epc_next;
            pending_reg <= pending_next;
            in_isr_reg  <= in_isr_next;
        end
    end

    // Strobes are forced low while reset is held so nothing fires in reset.
    assign bus.ld_ir   = fetch_strobe & ~rst;
    assign bus.rdMem   = mem_strobe & ~rst;
    assign bus.wrEn    = wb_strobe & ~rst;
    assign bus.updPC   = upd_strobe & ~rst;
    assign bus.int_ack = ack_strobe & ~rst;

    assign bus.PC      = pc_reg;
    assign bus.EPC     = epc_reg;
    assign bus.stage   = state_reg;
    assign bus.in_isr  = in_isr_reg;
    assign bus.halted  = (state_reg == HALT);

endmodule : risc_sequencer

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench for risc_sequencer: expected fetch addresses and interrupt
// return addresses are queued as each instruction is driven and consumed by a
// monitor when the sequencer fetches or acknowledges.
module tb_risc_sequencer;
    import risc_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        isr;
        int          gap;
    } fetch_t;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_t      fetch_q[$];
    logic [31:0] ack_q[$];

    risc_sequencer_if #(.AW(32)) bif ();
    risc_sequencer_if #(.AW(4))  bif4 ();

    risc_sequencer #(
        .AW       (32),
        .RESET_PC (32'h0),
        .INT_VEC  (32'h40)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    risc_sequencer #(
        .AW       (4),
        .RESET_PC (4'hF),
        .INT_VEC  (32'h40)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bif4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: consumes fetch and interrupt expectations as the DUT produces them.
    int cyc    = 0;
    int last_f = -1;
    bit ack_seen = 1'b0;
    always @(negedge clk) begin
        fetch_t      f;
        logic [31:0] e;
        #2;
        cyc++;
        if (rst) begin
            last_f   = -1;
            ack_seen = 1'b0;
        end else begin
            if (ack_seen) begin
                ack_seen = 1'b0;
                check_val("ack_expected", 64'(ack_q.size() > 0), 64'd1);
                if (ack_q.size() > 0) begin
                    e = ack_q.pop_front();
                    check_val("ack_epc", 64'(bif.EPC), 64'(e));
                    check_val("ack_vec_pc", 64'(bif.PC), 64'h40);
                    check_val("ack_in_isr", 64'(bif.in_isr), 64'd1);
                end
            end
            if (bif.int_ack) ack_seen = 1'b1;
            if (bif.ld_ir) begin
                check_val("fetch_expected", 64'(fetch_q.size() > 0), 64'd1);
                if (fetch_q.size() > 0) begin
                    f = fetch_q.pop_front();
                    check_val("fetch_pc", 64'(bif.PC), 64'(f.pc));
                    check_val("fetch_in_isr", 64'(bif.in_isr), 64'(f.isr));
                    if (f.gap != 0 && last_f >= 0) begin
                        check_val("fetch_gap", 64'(cyc - last_f), 64'(f.gap));
                    end
                end
                last_f = cyc;
            end
        end
    end

    // Runs one instruction starting at a FETCH negedge until the next FETCH/HALT.
    task automatic do_instr(input string name, input bit mem, input int stalls,
                            input bit br, input logic [31:0] tgt, input bit reti,
                            input bit halt, input int int_cyc,
                            input logic [31:0] exp_pc, input bit exp_isr,
                            input bit exp_ack, input logic [31:0] exp_epc,
                            input int exp_cyc);
        fetch_t      f;
        int          k   = 0;
        int          m   = 0;
        int          upd = 0;
        int          rd  = 0;
        int          ack = 0;
        int          wr  = 0;
        logic [31:0] pc0;
        pc0 = bif.PC;
        if (!halt) begin
            f.pc  = exp_pc;
            f.isr = exp_isr;
            f.gap = exp_cyc;
            fetch_q.push_back(f);
        end
        if (exp_ack) ack_q.push_back(exp_epc);
        bif.is_mem    = mem;
        bif.is_branch = br;
        bif.br_target = tgt;
        bif.is_reti   = reti;
        bif.is_halt   = halt;
        while (1) begin
            bif.stall = (bif.stage == MEM) && (m < stalls);
            if (bif.stage == MEM) m++;
            bif.INT = (k == int_cyc);
            #1;
            if (bif.updPC)   upd++;
            if (bif.rdMem)   rd++;
            if (bif.int_ack) ack++;
            if (bif.wrEn)    wr++;
            @(negedge clk);
            k++;
            if (bif.stage == FETCH || bif.stage == HALT) break;
            if (k >= 40) begin
                check_val({name, "_timeout"}, 64'(k), 64'(exp_cyc));
                break;
            end
        end
        bif.INT       = 1'b0;
        bif.stall     = 1'b0;
        bif.is_mem    = 1'b0;
        bif.is_branch = 1'b0;
        bif.br_target = '0;
        bif.is_reti   = 1'b0;
        bif.is_halt   = 1'b0;
        check_val({name, "_cycles"}, 64'(k), 64'(exp_cyc));
        check_val({name, "_updpc"}, 64'(upd), 64'd1);
        check_val({name, "_wren"}, 64'(wr), 64'd1);
        check_val({name, "_rdmem"}, 64'(rd), mem ? 64'(stalls + 1) : 64'd0);
        check_val({name, "_int_ack"}, 64'(ack), 64'(exp_ack));
        if (halt) begin
            check_val({name, "_halted"}, 64'(bif.halted), 64'd1);
            check_val({name, "_halt_pc"}, 64'(bif.PC), 64'(exp_pc));
        end
        $display("instr %-10s pc=0x%0h cycles=%0d updPC=%0d rdMem=%0d int_ack=%0d next_pc=0x%0h",
                 name, pc0, k, upd, rd, ack, bif.PC);
    endtask

    // Watchdog so a stuck sequencer still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        fetch_t f;
        int     upd;
        int     ldc;
        int     w;

        rst           = 1'b1;
        bif.INT       = 1'b1;
        bif.stall     = 1'b0;
        bif.is_mem    = 1'b0;
        bif.is_branch = 1'b0;
        bif.br_target = '0;
        bif.is_reti   = 1'b0;
        bif.is_halt   = 1'b0;
        bif4.INT       = 1'b0;
        bif4.stall     = 1'b0;
        bif4.is_mem    = 1'b0;
        bif4.is_branch = 1'b0;
        bif4.br_target = '0;
        bif4.is_reti   = 1'b0;
        bif4.is_halt   = 1'b0;

        // Reset state, with INT high to prove nothing latches or fires in reset.
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_stage", 64'(bif.stage), 64'(FETCH));
        check_val("rst_pc", 64'(bif.PC), 64'd0);
        check_val("rst_epc", 64'(bif.EPC), 64'd0);
        check_val("rst_in_isr", 64'(bif.in_isr), 64'd0);
        check_val("rst_halted", 64'(bif.halted), 64'd0);
        check_val("rst_ld_ir", 64'(bif.ld_ir), 64'd0);
        check_val("rst_updpc", 64'(bif.updPC), 64'd0);
        check_val("rst_int_ack", 64'(bif.int_ack), 64'd0);
        check_val("rst_rdmem", 64'(bif.rdMem), 64'd0);
        check_val("rst_wren", 64'(bif.wrEn), 64'd0);
        bif.INT = 1'b0;
        f.pc = 32'h0; f.isr = 1'b0; f.gap = 0;
        fetch_q.push_back(f);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line instructions, then a stalled memory access.
        do_instr("plain0", 0, 0, 0, 0, 0, 0, -1, 32'h1, 0, 0, 0, 4);
        do_instr("plain1", 0, 0, 0, 0, 0, 0, -1, 32'h2, 0, 0, 0, 4);
        do_instr("plain2", 0, 0, 0, 0, 0, 0, -1, 32'h3, 0, 0, 0, 4);
        do_instr("mem_stall", 1, 3, 0, 0, 0, 0, -1, 32'h4, 0, 0, 0, 8);
        do_instr("plain4", 0, 0, 0, 0, 0, 0, -1, 32'h5, 0, 0, 0, 4);

        // Branch with INT during EXEC: EPC gets the branch target.
        do_instr("br_int", 0, 0, 1, 32'h20, 0, 0, 2, 32'h40, 1, 1, 32'h20, 4);
        // INT inside the ISR is latched, then reti tail-chains.
        do_instr("isr_int", 0, 0, 0, 0, 0, 0, 1, 32'h41, 1, 0, 0, 4);
        do_instr("reti_tail", 0, 0, 0, 0, 1, 0, -1, 32'h40, 1, 1, 32'h20, 4);
        do_instr("reti_ret", 0, 0, 0, 0, 1, 0, -1, 32'h20, 0, 0, 0, 4);

        // Halt at PC 7, wake on INT ten cycles later.
        do_instr("br7", 0, 0, 1, 32'h7, 0, 0, -1, 32'h7, 0, 0, 0, 4);
        do_instr("halt", 0, 0, 0, 0, 0, 1, -1, 32'h8, 0, 0, 0, 4);
        upd = 0;
        ldc = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bif.updPC) upd++;
            if (bif.ld_ir) ldc++;
        end
        check_val("halt_pc_frozen", 64'(bif.PC), 64'h8);
        check_val("halt_still_halted", 64'(bif.halted), 64'd1);
        check_val("halt_no_updpc", 64'(upd), 64'd0);
        check_val("halt_no_fetch", 64'(ldc), 64'd0);
        f.pc = 32'h40; f.isr = 1'b1; f.gap = 0;
        fetch_q.push_back(f);
        ack_q.push_back(32'h8);
        @(negedge clk);
        bif.INT = 1'b1;
        #1;
        check_val("wake_int_ack", 64'(bif.int_ack), 64'd1);
        check_val("wake_updpc", 64'(bif.updPC), 64'd1);
        @(negedge clk);
        bif.INT = 1'b0;
        #1;
        check_val("wake_halted", 64'(bif.halted), 64'd0);
        check_val("wake_pc", 64'(bif.PC), 64'h40);
        check_val("wake_epc", 64'(bif.EPC), 64'h8);
        check_val("wake_stage", 64'(bif.stage), 64'(FETCH));
        $display("wake  pc=0x%0h epc=0x%0h halted=%0d", bif.PC, bif.EPC, bif.halted);
        do_instr("reti_wake", 0, 0, 0, 0, 1, 0, -1, 32'h8, 0, 0, 0, 4);

        // Minimum latency: INT only during WB.
        do_instr("int_wb", 0, 0, 0, 0, 0, 0, 3, 32'h40, 1, 1, 32'h9, 4);
        do_instr("reti9", 0, 0, 0, 0, 1, 0, -1, 32'h9, 0, 0, 0, 4);

        // Asynchronous reset in the middle of a memory stall.
        bif.is_mem = 1'b1;
        bif.stall  = 1'b1;
        w = 0;
        while (bif.stage != MEM && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_val("stall_reached_mem", 64'(bif.stage), 64'(MEM));
        repeat (2) @(negedge clk);
        #1;
        check_val("stall_held", 64'(bif.stage), 64'(MEM));
        check_val("stall_rdmem", 64'(bif.rdMem), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_pc", 64'(bif.PC), 64'd0);
        check_val("async_rst_stage", 64'(bif.stage), 64'(FETCH));
        check_val("async_rst_epc", 64'(bif.EPC), 64'd0);
        check_val("async_rst_rdmem", 64'(bif.rdMem), 64'd0);
        check_val("async_rst_ld_ir", 64'(bif.ld_ir), 64'd0);
        $display("reset mid-stall pc=0x%0h stage=%0d", bif.PC, bif.stage);
        @(negedge clk);
        bif.is_mem = 1'b0;
        bif.stall  = 1'b0;
        check_val("fetch_q_drained", 64'(fetch_q.size()), 64'd0);
        check_val("ack_q_drained", 64'(ack_q.size()), 64'd0);
        f.pc = 32'h0; f.isr = 1'b0; f.gap = 0;
        fetch_q.push_back(f);
        rst = 1'b0;
        #1;
        check_val("aw4_reset_pc", 64'(bif4.PC), 64'hF);
        check_val("aw4_reset_stage", 64'(bif4.stage), 64'(FETCH));

        // Both sequencers run one plain instruction; the 4-bit PC wraps 15 -> 0.
        do_instr("post_rst", 0, 0, 0, 0, 0, 0, -1, 32'h1, 0, 0, 0, 4);
        check_val("aw4_wrap_pc", 64'(bif4.PC), 64'h0);
        check_val("aw4_wrap_stage", 64'(bif4.stage), 64'(FETCH));
        $display("aw4 wrap pc=0x%0h stage=%0d", bif4.PC, bif4.stage);

        repeat (2) @(negedge clk);
        #3;
        check_val("final_fetch_q_empty", 64'(fetch_q.size()), 64'd0);
        check_val("final_ack_q_empty", 64'(ack_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_risc_sequencer
